muldiv: RTL

Multi-cycle multiply/divide unit for the MIPS core, the iterative counterpart to the single-cycle ALU. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO into architectural HI/LO registers. It sits beside the execute stage. The pipeline issues an op with a valid/busy handshake, stalls while `busy` is high, and reads `hi`/`lo` directly for MFHI/MFLO.

---
 rtl/muldiv.sv | 136 +++++++++++++
 1 files changed

// File: rtl/muldiv.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU plus MTHI/MTLO into architectural HI/LO.
// 34-cycle latency (accept to done) for mul/div, 1 cycle for MT; new issues are ignored while busy.
module muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        is_div, neg_q, neg_r, dz;
  logic [31:0] opa, acc_hi, acc_lo;

  logic        accept, start, mt_hi, mt_lo, done_nxt, fix_wr;
  logic        a_neg, b_neg;
  logic [31:0] a_abs, b_abs;
  logic [32:0] mul_sum, div_sh;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] prod, prod_fix;
  logic [31:0] q_fix, r_fix, fix_hi, fix_lo;

  // Operand conditioning: signed ops (op[0]==0) work on magnitudes
  always_comb begin
    accept = valid && (state == IDLE) && !cancel;
    start  = accept && !op[2];
    mt_hi  = accept && (op == 3'b100);
    mt_lo  = accept && (op == 3'b101);
    a_neg  = !op[0] && a[31];
    b_neg  = !op[0] && b[31];
    a_abs  = a_neg ? -a : a;
    b_abs  = b_neg ? -b : b;
  end

  // One iteration step: opa is the multiplicand or the divisor
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opa} : 33'd0);
    div_sh   = {acc_hi, acc_lo[31]};
    div_ge   = div_sh >= {1'b0, opa};
    div_diff = div_sh[31:0] - opa;
  end

  // Sign fix-up; a zero divisor leaves the remainder equal to the original dividend
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_q ? -prod : prod;
    q_fix    = dz ? 32'hFFFF_FFFF : (neg_q ? -acc_lo : acc_lo);
    r_fix    = neg_r ? -acc_hi : acc_hi;
    fix_hi   = is_div ? r_fix : prod_fix[63:32];
    fix_lo   = is_div ? q_fix : prod_fix[31:0];
  end

  always_comb begin
    state_nxt = state;
    fix_wr    = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (cancel)              state_nxt = IDLE;
        else if (cnt == 5'd31)   state_nxt = FIX;
      end
      FIX: begin
        state_nxt = IDLE;
        fix_wr    = !cancel;
      end
      default: state_nxt = IDLE;
    endcase
    done_nxt = fix_wr || mt_hi || mt_lo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= 5'd0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      opa    <= 32'd0;
      acc_hi <= 32'd0;
      acc_lo <= 32'd0;
    end else if (start) begin
      cnt    <= 5'd0;
      is_div <= op[1];
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= op[1] && a_neg;
      dz     <= op[1] && (b == 32'd0);
      opa    <= op[1] ? b_abs : a_abs;
      acc_hi <= 32'd0;
      acc_lo <= op[1] ? a_abs : b_abs;
    end else if (state == RUN) begin
      cnt <= cnt + 5'd1;
      if (is_div) begin
        acc_hi <= div_ge ? div_diff : div_sh[31:0];
        acc_lo <= {acc_lo[30:0], div_ge};
      end else begin
        acc_hi <= mul_sum[32:1];
        acc_lo <= {mul_sum[0], acc_lo[31:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else begin
      if (mt_hi)       hi <= a;
      else if (fix_wr) hi <= fix_hi;
      if (mt_lo)       lo <= a;
      else if (fix_wr) lo <= fix_lo;
    end
  end

  assign busy = (state != IDLE);

endmodule
